// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W = $clog2(MAX_BURST_DEF + 1);

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last+1 upward, wrapping.
// Zero latency; no backpressure (pure function of req and last).
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last) + k) % NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        idx     = IW'(j);
        pick[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler for the async FIFO write port; grant registered one cycle after request,
// one idle bubble per arbitration, at most MAX_BURST words per grant; wfull stalls the owner in place.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata_in,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic                  busy
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            busy_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [CW-1:0]   burst_cnt, cnt_nxt;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            owner_req;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // While granted, last is the owner index.
  always_comb begin
    owner_req = req[last];
    winc      = (state == GRANT) && owner_req && !wfull;
    wdata     = (state == GRANT) ? wdata_in[int'(last)*WIDTH +: WIDTH] : '0;
    ack       = gnt & {NREQ{winc}};
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    last_nxt  = last;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = pick;
          busy_nxt  = 1'b1;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (winc && (burst_cnt != LAST_BEAT)) begin
          cnt_nxt = burst_cnt + 1'b1;
        end else if (winc || !owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      last      <= LAST_RST;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector table plus hand sequences and a randomized invariant phase for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;

  logic        wclk;
  logic        wrstn;
  logic [3:0]  req;
  logic [31:0] wdata_in;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (4)
  ) dut (
    .wclk     (wclk),
    .wrstn    (wrstn),
    .req      (req),
    .wdata_in (wdata_in),
    .ack      (ack),
    .gnt      (gnt),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        wfull;
    logic [31:0] din;
    logic [3:0]  egnt;
    logic        ewinc;
    logic [7:0]  edat;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic wf, input logic [31:0] d,
                     input logic [3:0] eg, input logic ew, input logic [7:0] ed, input logic eb);
    vec_t v;
    v.rst = r; v.req = rq; v.wfull = wf; v.din = d;
    v.egnt = eg; v.ewinc = ew; v.edat = ed; v.ebusy = eb;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Called at the sampling point (negedge); expected ack follows from expected gnt/winc.
  task automatic chk(input string nm, input logic [3:0] eg, input logic ew,
                     input logic [7:0] ed, input logic eb);
    cmp({nm, "_gnt"},  32'(gnt),  32'(eg));
    cmp({nm, "_winc"}, 32'(winc), 32'(ew));
    cmp({nm, "_busy"}, 32'(busy), 32'(eb));
    cmp({nm, "_ack"},  32'(ack),  32'(ew ? eg : 4'b0000));
    if (eb) cmp({nm, "_wdata"}, 32'(wdata), 32'(ed));
  endtask

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; wfull = 1'b0; wdata_in = '0;
    wrstn = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    cmp("rst_gnt",  32'(gnt),  32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_winc", 32'(winc), 32'd0);
    cmp("rst_ack",  32'(ack),  32'd0);
    wrstn = 1'b1;
    next_cycle();
  endtask

  initial begin
    wrstn = 1'b0; req = '0; wfull = 1'b0; wdata_in = '0;

    // Single requester: idle, 4 writes, bubble, regrant.
    add(1, 4'b0001, 0, 32'h000000A5, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 32'h000000A5, 4'b0001, 1, 8'hA5, 1);
    add(0, 4'b0001, 0, 32'h000000A5, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0001, 0, 32'h000000A5, 4'b0001, 1, 8'hA5, 1);

    // Requester 2 stalled by wfull for 5 cycles after 2 writes.
    add(1, 4'b0100, 0, 32'h44C32211, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0100, 0, 32'h44C32211, 4'b0100, 1, 8'hC3, 1);
    for (int i = 0; i < 5; i++) add(0, 4'b0100, 1, 32'h44C32211, 4'b0100, 0, 8'hC3, 1);
    for (int i = 0; i < 2; i++) add(0, 4'b0100, 0, 32'h44C32211, 4'b0100, 1, 8'hC3, 1);
    add(0, 4'b0100, 0, 32'h44C32211, 4'b0000, 0, 8'h00, 0);

    // Requester 1 drops after one write; pending requester 2 is next.
    add(1, 4'b0010, 0, 32'h44332211, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0110, 0, 32'h44332211, 4'b0010, 1, 8'h22, 1);
    add(0, 4'b0100, 0, 32'h44332211, 4'b0010, 0, 8'h22, 1);
    add(0, 4'b0100, 0, 32'h44332211, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0100, 0, 32'h44332211, 4'b0100, 1, 8'h33, 1);

    // wfull asserted together with the owner's request: no write, grant held.
    add(1, 4'b1000, 1, 32'h5A000000, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b1000, 1, 32'h5A000000, 4'b1000, 0, 8'h5A, 1);
    add(0, 4'b1000, 0, 32'h5A000000, 4'b1000, 1, 8'h5A, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req = vecs[i].req; wfull = vecs[i].wfull; wdata_in = vecs[i].din;
      @(negedge wclk);
      chk($sformatf("v%0d", i), vecs[i].egnt, vecs[i].ewinc, vecs[i].edat, vecs[i].ebusy);
      next_cycle();
    end

    // All requesting: order 0,1,2,3,0 with one bubble before each grant.
    do_reset();
    req = 4'b1111; wdata_in = 32'h44332211;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] eg;
      logic [31:0] d;
      eg = 4'b0001 << (g % 4);
      d = wdata_in;
      @(negedge wclk);
      chk($sformatf("rr%0d_idle", g), 4'b0000, 1'b0, 8'h00, 1'b0);
      next_cycle();
      for (int w = 0; w < 4; w++) begin
        @(negedge wclk);
        chk($sformatf("rr%0d_w%0d", g, w), eg, 1'b1, d[(g % 4)*8 +: 8], 1'b1);
        next_cycle();
      end
    end

    // Asynchronous reset mid-burst with requester 3 owning.
    do_reset();
    req = 4'b1000; wdata_in = 32'h5A332211;
    @(negedge wclk);
    chk("ar_idle", 4'b0000, 1'b0, 8'h00, 1'b0);
    next_cycle();
    @(negedge wclk);
    chk("ar_w0", 4'b1000, 1'b1, 8'h5A, 1'b1);
    next_cycle();
    #2 wrstn = 1'b0;
    #1;
    cmp("ar_async_gnt",  32'(gnt),  32'd0);
    cmp("ar_async_busy", 32'(busy), 32'd0);
    cmp("ar_async_winc", 32'(winc), 32'd0);
    cmp("ar_async_ack",  32'(ack),  32'd0);
    req = 4'b1001;
    @(negedge wclk);
    wrstn = 1'b1;
    next_cycle();
    @(negedge wclk);
    chk("ar_regrant", 4'b0001, 1'b1, 8'h11, 1'b1);
    next_cycle();

    // Random traffic with invariant checks.
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      int oi;
      req = 4'($urandom_range(0, 15));
      wfull = ($urandom_range(0, 3) == 0);
      wdata_in = $urandom;
      @(negedge wclk);
      cmp("rnd_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (wfull) cmp("rnd_winc_wfull", 32'(winc), 32'd0);
      cmp("rnd_ack", 32'(ack), 32'(gnt & {4{winc}}));
      cmp("rnd_winc_model", 32'(winc), 32'((|(gnt & req)) & ~wfull));
      cmp("rnd_busy", 32'(busy), 32'(|gnt));
      oi = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) oi = i;
      if (winc) cmp("rnd_wdata", 32'(wdata), 32'(wdata_in[oi*8 +: 8]));
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
